// File: rtl/ext_io_bridge.sv
// Pad-ring boundary for the DTW core: single-beat SRAM sequencer with tri-state turnaround,
// plus a registered-input, FIFO-buffered sample stream with overflow-safe registered ready.
`timescale 1ns/1ps

module ext_io_bridge #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int SW         = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          mem_req_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [DW-1:0] mem_wdata_i,
    output logic          mem_gnt_o,
    output logic          mem_rvalid_o,
    output logic [DW-1:0] mem_rdata_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o,
    input  logic [DW-1:0] data_i,
    output logic          data_oe_o,
    output logic          WR_o,
    output logic          CS_o,
    input  logic [SW-1:0] Sin_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic [SW-1:0] s_data_o,
    output logic          s_valid_o,
    input  logic          s_ready_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} bus_state_t;

    bus_state_t state, state_next;
    logic [1:0] rd_cnt;
    logic       grant;
    logic       read_done;

    // Grant is gated by reset so nothing is accepted while the block is held in reset.
    assign grant     = rst_i & mem_req_i & (state == IDLE);
    assign mem_gnt_o = grant;
    assign read_done = (state == READ) && (rd_cnt == 2'(RD_LAT));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = mem_we_i ? WRITE : READ;
            WRITE:   state_next = TURN;
            TURN:    state_next = IDLE;
            READ:    if (read_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pad strobes are decoded from the next state so they are flop outputs aligned with the state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            CS_o         <= 1'b1;
            WR_o         <= 1'b1;
            data_oe_o    <= 1'b0;
            addr_o       <= '0;
            data_o       <= '0;
            rd_cnt       <= '0;
            mem_rvalid_o <= 1'b0;
            mem_rdata_o  <= '0;
        end else begin
            CS_o         <= !((state_next == WRITE) || (state_next == READ));
            WR_o         <= (state_next != WRITE);
            data_oe_o    <= (state_next == WRITE);
            rd_cnt       <= (state_next == READ) ? rd_cnt + 2'd1 : 2'd0;
            mem_rvalid_o <= read_done;
            if (read_done) begin
                mem_rdata_o <= data_i;
            end
            if (grant) begin
                addr_o <= mem_addr_i;
                if (mem_we_i) begin
                    data_o <= mem_wdata_i;
                end
            end
        end
    end

    logic [SW-1:0] in_data;
    logic          in_valid;
    logic [SW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next, occ_next;
    logic          accept, push, pop;

    assign accept    = valid_i & ready_o;
    assign push      = in_valid;
    assign pop       = s_valid_o & s_ready_i;
    assign s_valid_o = (count != '0);
    assign s_data_o  = fifo_mem[rd_ptr];

    // Occupancy counts the input register too, so ready drops before the FIFO can overflow.
    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
        occ_next   = count_next + CW'(accept);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            in_valid <= 1'b0;
            in_data  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_o  <= 1'b0;
        end else begin
            in_valid <= accept;
            if (accept) begin
                in_data <= Sin_i;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count   <= count_next;
            ready_o <= (occ_next < CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_ext_io_bridge.sv
// Bench for ext_io_bridge: directed bus/stream sequences plus randomized traffic,
// checked against a behavioural SRAM image and a queue-based stream model.
`timescale 1ns/1ps

module tb_ext_io_bridge;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int SW         = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int RD_LAT_A   = 2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          rst_i;
    logic          mem_req_i, mem_we_i;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_wdata_i;
    logic          mem_gnt_o, mem_rvalid_o;
    logic [DW-1:0] mem_rdata_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o, data_i;
    logic          data_oe_o, WR_o, CS_o;
    logic [SW-1:0] Sin_i, s_data_o;
    logic          valid_i, ready_o, s_valid_o, s_ready_i;

    logic          req_b, we_b, gnt_b, rvalid_b, oe_b, wr_b, cs_b;
    logic [AW-1:0] addr_in_b, addr_b;
    logic [DW-1:0] wdata_b, rdata_b, data_out_b, data_in_b;
    logic [SW-1:0] sin_b, sdata_b;
    logic          valid_b, ready_b, svalid_b, sready_b;

    ext_io_bridge #(.AW(AW), .DW(DW), .SW(SW), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT_A)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o(mem_rdata_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
        .data_oe_o(data_oe_o), .WR_o(WR_o), .CS_o(CS_o),
        .Sin_i(Sin_i), .valid_i(valid_i), .ready_o(ready_o),
        .s_data_o(s_data_o), .s_valid_o(s_valid_o), .s_ready_i(s_ready_i)
    );

    // Second instance with single-cycle read latency, used for back-to-back reads.
    ext_io_bridge #(.AW(AW), .DW(DW), .SW(SW), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(1)) dut_b (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_i(req_b), .mem_we_i(we_b), .mem_addr_i(addr_in_b),
        .mem_wdata_i(wdata_b), .mem_gnt_o(gnt_b), .mem_rvalid_o(rvalid_b),
        .mem_rdata_o(rdata_b), .addr_o(addr_b), .data_o(data_out_b), .data_i(data_in_b),
        .data_oe_o(oe_b), .WR_o(wr_b), .CS_o(cs_b),
        .Sin_i(sin_b), .valid_i(valid_b), .ready_o(ready_b),
        .s_data_o(sdata_b), .s_valid_o(svalid_b), .s_ready_i(sready_b)
    );

    logic [DW-1:0] sram    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    // SRAM device model driven purely from the pads.
    always_comb data_i    = (!CS_o && WR_o) ? sram[addr_o] : '0;
    always_comb data_in_b = (!cs_b && wr_b) ? sram[addr_b] : '0;
    always @(posedge clk_i) if (!CS_o && !WR_o && data_oe_o) sram[addr_o] = data_o;

    int cycle = 0;
    always @(posedge clk_i) cycle <= cycle + 1;

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] beat_val[$];
    int            beat_avail[$];
    int            accepted_total = 0;
    int            popped_total   = 0;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One stream cycle starting at a falling edge; the model is a queue of accepted beats.
    task automatic stream_cycle(input bit v, input bit sr, input logic [SW-1:0] value);
        bit acc, pp, head_ready;
        valid_i   = v;
        s_ready_i = sr;
        Sin_i     = value;
        head_ready = 1'b0;
        if (beat_val.size() != 0) head_ready = (beat_avail[0] <= cycle);
        check_output("ready_o", 64'(ready_o), 64'(beat_val.size() < FIFO_DEPTH));
        check_output("s_valid_o", 64'(s_valid_o), 64'(head_ready));
        acc = v && ready_o;
        pp  = s_valid_o && sr;
        if (pp && beat_val.size() != 0) begin
            check_output("s_data_o", 64'(s_data_o), 64'(beat_val[0]));
            void'(beat_val.pop_front());
            void'(beat_avail.pop_front());
            popped_total++;
        end
        if (acc) begin
            beat_val.push_back(value);
            beat_avail.push_back(cycle + 2);
            accepted_total++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Single access on the main instance, bounded waits on grant and read data.
    task automatic apply_stimulus(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n;
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        #1;
        n = 0;
        while (!mem_gnt_o && n < 20) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check_output("bus_gnt", 64'(mem_gnt_o), 64'd1);
        if (mem_gnt_o) begin
            @(posedge clk_i);
            @(negedge clk_i);
            mem_req_i = 1'b0;
            if (we) begin
                ref_mem[addr] = wdata;
            end else begin
                n = 0;
                while (!mem_rvalid_o && n < 8) begin
                    @(negedge clk_i);
                    n++;
                end
                check_output("rd_latency", 64'(n), 64'(RD_LAT_A));
                check_output("rd_data", 64'(mem_rdata_o), 64'(ref_mem[addr]));
            end
        end
    endtask

    initial begin
        logic [AW-1:0] b2b_addr[$];
        logic [AW-1:0] a;
        logic [DW-1:0] exp_data;
        int            base;

        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[10'h2A0]    = 32'h12345678;
        ref_mem[10'h2A0] = 32'h12345678;

        rst_i = 1'b0;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 10'h3FF; mem_wdata_i = '1;
        valid_i = 1'b1; Sin_i = '1; s_ready_i = 1'b1;
        req_b = 1'b0; we_b = 1'b0; addr_in_b = '0; wdata_b = '0;
        sin_b = '0; valid_b = 1'b0; sready_b = 1'b0;

        @(negedge clk_i);
        @(negedge clk_i);
        check_output("rst_cs", 64'(CS_o), 64'd1);
        check_output("rst_wr", 64'(WR_o), 64'd1);
        check_output("rst_oe", 64'(data_oe_o), 64'd0);
        check_output("rst_addr", 64'(addr_o), 64'd0);
        check_output("rst_data", 64'(data_o), 64'd0);
        check_output("rst_gnt", 64'(mem_gnt_o), 64'd0);
        check_output("rst_rvalid", 64'(mem_rvalid_o), 64'd0);
        check_output("rst_rdata", 64'(mem_rdata_o), 64'd0);
        check_output("rst_ready", 64'(ready_o), 64'd0);
        check_output("rst_svalid", 64'(s_valid_o), 64'd0);

        mem_req_i = 1'b0; valid_i = 1'b0; s_ready_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_output("ready_before_edge", 64'(ready_o), 64'd0);
        @(negedge clk_i);
        check_output("ready_first_edge", 64'(ready_o), 64'd1);

        $display("[TB] directed write then read");
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 10'h155; mem_wdata_i = 32'hDEADBEEF;
        #1;
        check_output("wr_gnt_T", 64'(mem_gnt_o), 64'd1);
        @(negedge clk_i);
        ref_mem[10'h155] = 32'hDEADBEEF;
        mem_we_i = 1'b0; mem_addr_i = 10'h2A0;
        #1;
        check_output("wr_cs", 64'(CS_o), 64'd0);
        check_output("wr_wr", 64'(WR_o), 64'd0);
        check_output("wr_oe", 64'(data_oe_o), 64'd1);
        check_output("wr_addr", 64'(addr_o), 64'h155);
        check_output("wr_data", 64'(data_o), 64'hDEADBEEF);
        check_output("wr_gnt_T1", 64'(mem_gnt_o), 64'd0);
        @(negedge clk_i);
        check_output("turn_cs", 64'(CS_o), 64'd1);
        check_output("turn_wr", 64'(WR_o), 64'd1);
        check_output("turn_oe", 64'(data_oe_o), 64'd0);
        check_output("turn_gnt", 64'(mem_gnt_o), 64'd0);
        @(negedge clk_i);
        check_output("rd_gnt_T3", 64'(mem_gnt_o), 64'd1);
        check_output("idle_oe", 64'(data_oe_o), 64'd0);
        check_output("idle_addr_hold", 64'(addr_o), 64'h155);
        for (int k = 1; k <= RD_LAT_A; k++) begin
            @(negedge clk_i);
            mem_req_i = 1'b0;
            check_output("rd_cs_low", 64'(CS_o), 64'd0);
            check_output("rd_wr_high", 64'(WR_o), 64'd1);
            check_output("rd_oe_low", 64'(data_oe_o), 64'd0);
            check_output("rd_rvalid_early", 64'(mem_rvalid_o), 64'd0);
        end
        @(negedge clk_i);
        check_output("rd_rvalid", 64'(mem_rvalid_o), 64'd1);
        check_output("rd_rdata", 64'(mem_rdata_o), 64'h12345678);
        check_output("rd_cs_end", 64'(CS_o), 64'd1);
        check_output("rd_oe_after", 64'(data_oe_o), 64'd0);
        @(negedge clk_i);
        check_output("rd_rvalid_pulse", 64'(mem_rvalid_o), 64'd0);
        check_output("rd_rdata_hold", 64'(mem_rdata_o), 64'h12345678);
        apply_stimulus(1'b0, 10'h155, '0);

        $display("[TB] back-to-back reads, single-cycle latency");
        req_b = 1'b1; we_b = 1'b0; addr_in_b = 10'($urandom);
        for (int k = 0; k <= 8; k++) begin
            #1;
            check_output("b2b_gnt", 64'(gnt_b), 64'((k % 2 == 0) && (k < 8)));
            check_output("b2b_cs", 64'(cs_b), 64'(k % 2 == 0));
            check_output("b2b_oe", 64'(oe_b), 64'd0);
            check_output("b2b_rvalid", 64'(rvalid_b), 64'((k % 2 == 0) && (k >= 2)));
            if (k % 2 == 0 && k >= 2 && b2b_addr.size() != 0) begin
                a = b2b_addr.pop_front();
                check_output("b2b_rdata", 64'(rdata_b), 64'(ref_mem[a]));
            end
            if (k % 2 == 0 && k < 8) b2b_addr.push_back(addr_in_b);
            if (k % 2 == 1) addr_in_b = 10'($urandom);
            if (k == 7) req_b = 1'b0;
            @(negedge clk_i);
        end

        $display("[TB] randomized bus accesses");
        for (int i = 0; i < 40; i++) begin
            a = 10'h300 + 10'($urandom_range(0, 15));
            apply_stimulus(1'($urandom), a, $urandom);
        end

        $display("[TB] stream fill with core stalled");
        for (int i = 1; i <= 8; i++) stream_cycle(1'b1, 1'b0, SW'(accepted_total + 1));
        check_output("fill_accepted", 64'(accepted_total), 64'd4);
        check_output("fill_ready", 64'(ready_o), 64'd0);
        for (int i = 0; i < 8; i++) stream_cycle(1'b0, 1'b1, '0);
        check_output("fill_popped", 64'(popped_total), 64'd4);

        $display("[TB] stream throughput");
        base = accepted_total;
        for (int i = 0; i < 100; i++) stream_cycle(1'b1, 1'b1, SW'(1000 + i));
        check_output("thru_accepted", 64'(accepted_total - base), 64'd100);
        for (int i = 0; i < 4; i++) stream_cycle(1'b0, 1'b1, '0);
        check_output("thru_drained", 64'(popped_total), 64'(accepted_total));

        $display("[TB] randomized stream");
        for (int i = 0; i < 300; i++) stream_cycle(1'($urandom), ($urandom_range(0, 2) == 0), $urandom);
        for (int i = 0; i < 10; i++) stream_cycle(1'b0, 1'b1, '0);
        check_output("rand_drained", 64'(beat_val.size()), 64'd0);
        check_output("rand_balance", 64'(popped_total), 64'(accepted_total));

        $display("[TB] reset during a write");
        exp_data = 32'h5A5A5A5A;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 10'h0AA; mem_wdata_i = exp_data;
        #1;
        check_output("mw_gnt", 64'(mem_gnt_o), 64'd1);
        @(negedge clk_i);
        check_output("mw_cs_before", 64'(CS_o), 64'd0);
        #2;
        rst_i = 1'b0;
        #1;
        check_output("mw_cs", 64'(CS_o), 64'd1);
        check_output("mw_wr", 64'(WR_o), 64'd1);
        check_output("mw_oe", 64'(data_oe_o), 64'd0);
        check_output("mw_data", 64'(data_o), 64'd0);
        check_output("mw_gnt_rst", 64'(mem_gnt_o), 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check_output("mw_gnt_hold", 64'(mem_gnt_o), 64'd0);
            check_output("mw_cs_hold", 64'(CS_o), 64'd1);
        end
        rst_i = 1'b1;
        #1;
        check_output("mw_gnt_release", 64'(mem_gnt_o), 64'd1);
        @(negedge clk_i);
        mem_req_i = 1'b0;
        check_output("mw_rewrite_data", 64'(data_o), 64'(exp_data));
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_io_bridge.md
Name: ext_io_bridge

Overview:
Synchronous boundary block between the DTW core and the pad ring. It registers every pad-facing signal. It sequences single-beat accesses on the external SRAM bus, including tri-state turnaround after writes. It buffers the incoming sample stream through an input register and a parametrised FIFO, with a registered, overflow-safe ready.

Parameters:
AW, 10, external SRAM address width
DW, 32, external SRAM data width
SW, 32, sample stream width
FIFO_DEPTH, 4, stream FIFO entries; must be a power of 2 and at least 2
RD_LAT, 1, SRAM read latency in cycles (1..3): cycles CS_o is held low before data_i is sampled

Ports:
clk_i  in  1  single clock
rst_i  in  1  asynchronous, active-low reset
mem_req_i  in  1  core access request; held stable until granted
mem_we_i  in  1  1 = write, 0 = read
mem_addr_i  in  AW  access address
mem_wdata_i  in  DW  write data
mem_gnt_o  out  1  request accepted this cycle
mem_rvalid_o  out  1  one-cycle read-data strobe
mem_rdata_o  out  DW  read data
addr_o  out  AW  to pad: SRAM address
data_o  out  DW  to pad: SRAM write data
data_i  in  DW  from pad: SRAM read data
data_oe_o  out  1  pad output enable (pad OEN = ~data_oe_o)
WR_o  out  1  SRAM write strobe, active-low
CS_o  out  1  SRAM chip select, active-low
Sin_i  in  SW  from pad: sample
valid_i  in  1  from pad: sample valid
ready_o  out  1  to pad: sample ready, registered
s_data_o  out  SW  FIFO head to core
s_valid_o  out  1  FIFO non-empty
s_ready_i  in  1  core pops the head

Behaviour:
- Reset (rst_i = 0) takes effect immediately and asynchronously:
  - Pad and bus outputs: CS_o = 1, WR_o = 1, data_oe_o = 0, addr_o = 0, data_o = 0.
  - Core-side outputs: mem_gnt_o = 0, mem_rvalid_o = 0, mem_rdata_o = 0.
  - Stream: ready_o = 0, FIFO empty, s_valid_o = 0. s_data_o is don't-care while s_valid_o = 0.
  - FSM goes to IDLE. An in-flight read is discarded and never returns rvalid.
- Bus FSM states: IDLE, WRITE, READ, TURN. All pad outputs come from flops.
- IDLE:
  - mem_gnt_o = mem_req_i, combinational, and only in this state.
  - On grant at edge T: latch addr, we and wdata. A write goes to WRITE; a read goes to READ.
- WRITE (cycle T+1): CS_o = 0, WR_o = 0, data_oe_o = 1, addr_o and data_o driven from the latch. Next state is TURN.
- TURN (one cycle): CS_o = 1, WR_o = 1, data_oe_o = 0. Next state is IDLE. The earliest next grant is at T+3.
- READ (cycles T+1 .. T+RD_LAT):
  - CS_o = 0, WR_o = 1, data_oe_o = 0.
  - data_i is sampled at the end of cycle T+RD_LAT.
  - mem_rvalid_o = 1 with mem_rdata_o in cycle T+RD_LAT+1; mem_rdata_o holds afterwards.
  - Next state is IDLE, so a grant is possible in T+RD_LAT+1. Back-to-back reads need no turnaround.
- data_oe_o is never 1 in the cycle immediately before or after a read's CS_o-low window.
- addr_o and data_o hold their last value while idle.
- Stream path:
  - Beat accepted at edge E when valid_i & ready_o; it is captured into the input register (Sin_i plus a valid bit).
  - The beat is pushed into the FIFO at E+1, and s_valid_o rises after E+1. Pad-to-core latency is 2 cycles.
  - Occupancy O = FIFO count + input-register valid.
  - ready_o is registered: ready_o <= (O_next < FIFO_DEPTH), where O_next includes the push and pop of the current edge.
  - After reset release, ready_o rises at the first edge.
  - A beat is never dropped or duplicated, and the FIFO never overflows.
  - Pop when s_valid_o & s_ready_i. A simultaneous push and pop when full leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - Ordering is strictly FIFO.
- The bus path and the stream path are independent; there is no arbitration between them.

Test Plan:
- Reset mid-write: assert rst_i = 0 in the WRITE cycle -> CS_o, WR_o = 1 and data_oe_o = 0 in the same cycle without waiting for a clock edge; no further gnt until release.
- Write at T (addr 0x155, data 0xDEADBEEF) -> T+1: CS_o = 0, WR_o = 0, data_oe_o = 1, addr_o = 0x155, data_o = 0xDEADBEEF; T+2: all deasserted; mem_gnt_o low in T+1 and T+2, high again at T+3.
- Write then read, RD_LAT = 2, bench drives data_i = 0x12345678 -> read CS_o low T+1..T+2 with data_oe_o = 0; mem_rvalid_o = 1 and mem_rdata_o = 0x12345678 at T+3.
- Back-to-back reads, RD_LAT = 1 -> CS_o low in alternate cycles, one grant every 2 cycles, no TURN cycle.
- Stream, FIFO_DEPTH = 4, s_ready_i = 0, valid_i held with Sin_i = 1, 2, 3, ... -> exactly 4 beats accepted, then ready_o = 0; raising s_ready_i yields 1, 2, 3, 4 in order, and ready_o returns 1 cycle after the first pop.
- Stream throughput, s_ready_i = 1 continuously, 100 sequential beats -> ready_o stays 1, s_valid_o first high 2 cycles after the first accept, all values out in order, none lost.
